map_scheduler: RTL and testbench

MAP_SCHEDULER -- requirements
Module: map_scheduler

---
 rtl/map_scheduler_if.sv | 39 +++
 rtl/map_scheduler.sv | 149 ++++++++++++++
 tb/tb_map_scheduler.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/map_scheduler_if.sv
// Handshake bundle between a job controller, a pixel source and the img2col mapper.
// master drives requests, pixels and map_finish; slave is the scheduler itself.
interface map_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_W       = 6
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CH_W-1:0]       cfg_num_ch;
  logic                  abort;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  map_start;
  logic [DATA_WIDTH-1:0] map_new1;
  logic                  map_flag;
  logic                  map_finish;
  logic [CH_W-1:0]       ch_idx;
  logic                  busy;
  logic                  done;
  logic                  err_timeout;
  logic                  err_early;

  modport master (
    output cfg_valid, cfg_num_ch, abort,
    output s_valid, s_data, map_finish,
    input  cfg_ready, s_ready, map_start,
    input  map_new1, map_flag, ch_idx,
    input  busy, done, err_timeout, err_early
  );

  modport slave (
    input  cfg_valid, cfg_num_ch, abort,
    input  s_valid, s_data, map_finish,
    output cfg_ready, s_ready, map_start,
    output map_new1, map_flag, ch_idx,
    output busy, done, err_timeout, err_early
  );
endinterface

// File: rtl/map_scheduler.sv
// Per-channel sequencer feeding ROW*ROW pixels to an img2col mapper and awaiting map_finish.
// Ports: clk, nrst (async active-high reset), bus (map_scheduler_if.slave).
module map_scheduler #(
  parameter int ROW        = 28,
  parameter int DATA_WIDTH = 16,
  parameter int CH_W       = 6,
  parameter int TIMEOUT    = 4096
) (
  input  logic           clk,
  input  logic           nrst,
  map_scheduler_if.slave bus
);
  localparam int NPIX = ROW * ROW;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] PIX_LAST  = PW'(NPIX - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, START, FEED, WAIT, NEXT, DONE
  } state_t;

  state_t                state;
  logic [CH_W-1:0]       num_ch;
  logic [PW-1:0]         pix_cnt;
  logic [TW-1:0]         wait_cnt;
  logic                  cfg_ready;
  logic                  s_ready;
  logic                  map_start;
  logic [DATA_WIDTH-1:0] map_new1;
  logic                  map_flag;
  logic [CH_W-1:0]       ch_idx;
  logic                  busy;
  logic                  done;
  logic                  err_timeout;
  logic                  err_early;
  logic                  hs;

  // s_ready is registered and only high in FEED
  assign hs = bus.s_valid & s_ready;

  assign bus.cfg_ready   = cfg_ready;
  assign bus.s_ready     = s_ready;
  assign bus.map_start   = map_start;
  assign bus.map_new1    = map_new1;
  assign bus.map_flag    = map_flag;
  assign bus.ch_idx      = ch_idx;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.err_timeout = err_timeout;
  assign bus.err_early   = err_early;

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state       <= IDLE;
      num_ch      <= '0;
      pix_cnt     <= '0;
      wait_cnt    <= '0;
      cfg_ready   <= 1'b1;
      s_ready     <= 1'b0;
      map_start   <= 1'b0;
      map_new1    <= '0;
      map_flag    <= 1'b0;
      ch_idx      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_early   <= 1'b0;
    end else begin
      map_start <= 1'b0;
      map_flag  <= 1'b0;
      done      <= 1'b0;
      if (bus.abort && state != IDLE) begin
        // ch_idx and error flags intentionally kept for post-mortem
        state     <= IDLE;
        cfg_ready <= 1'b1;
        s_ready   <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.cfg_valid) begin
              if (bus.cfg_num_ch != '0) begin
                num_ch      <= bus.cfg_num_ch;
                ch_idx      <= '0;
                err_timeout <= 1'b0;
                err_early   <= 1'b0;
                map_start   <= 1'b1;
                cfg_ready   <= 1'b0;
                busy        <= 1'b1;
                state       <= START;
              end else begin
                done <= 1'b1;
              end
            end
          end
          START: begin
            pix_cnt <= '0;
            s_ready <= 1'b1;
            state   <= FEED;
            if (bus.map_finish) err_early <= 1'b1;
          end
          FEED: begin
            if (bus.map_finish) err_early <= 1'b1;
            if (hs) begin
              map_new1 <= bus.s_data;
              map_flag <= 1'b1;
              // pix_cnt holds at the last index instead of wrapping
              if (pix_cnt == PIX_LAST) begin
                s_ready  <= 1'b0;
                wait_cnt <= '0;
                state    <= WAIT;
              end else begin
                pix_cnt <= pix_cnt + PW'(1);
              end
            end
          end
          WAIT: begin
            if (bus.map_finish) begin
              state <= NEXT;
            end else if (wait_cnt == WAIT_LAST) begin
              err_timeout <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              wait_cnt <= wait_cnt + TW'(1);
            end
          end
          NEXT: begin
            if (ch_idx == num_ch - CH_W'(1)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              ch_idx    <= ch_idx + CH_W'(1);
              map_start <= 1'b1;
              state     <= START;
            end
          end
          DONE: begin
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_map_scheduler.sv
// Directed bench for map_scheduler with ROW=4, TIMEOUT=8.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_map_scheduler;
  logic clk;
  logic nrst;
  int checks;
  int errors;
  int n_start;
  int n_flag;
  int n_done;
  int low_run;
  int unstable;
  int base;
  int bad;
  logic [15:0] pix;
  logic [15:0] last_val;
  logic [15:0] flag_q[$];

  map_scheduler_if #(.DATA_WIDTH(16), .CH_W(6)) bus ();

  map_scheduler #(
    .ROW(4), .DATA_WIDTH(16), .CH_W(6), .TIMEOUT(8)
  ) dut (
    .clk(clk), .nrst(nrst), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.map_start) n_start++;
    if (bus.map_flag) begin
      n_flag++;
      flag_q.push_back(bus.map_new1);
    end
    if (bus.done) n_done++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // {cfg_ready,s_ready,map_start,map_flag,
  //  busy,done,err_timeout,err_early}
  function automatic logic [7:0] st();
    return {bus.cfg_ready, bus.s_ready,
            bus.map_start, bus.map_flag,
            bus.busy, bus.done,
            bus.err_timeout, bus.err_early};
  endfunction

  task automatic clr();
    @(posedge clk);
    n_start = 0;
    n_flag = 0;
    n_done = 0;
    flag_q.delete();
  endtask

  task automatic start_job(input int num);
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_num_ch = 6'(num);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic feed(input int n,
                      input int stall_at,
                      input int stall_len,
                      input int fin_at);
    int sent;
    int waited;
    int cyc;
    sent = 0;
    waited = 0;
    cyc = 0;
    low_run = 0;
    unstable = 0;
    while (sent < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (sent > 0) begin
        if (bus.map_flag) begin
          last_val = bus.map_new1;
        end else begin
          low_run++;
          if (bus.map_new1 !== last_val)
            unstable++;
        end
      end
      bus.map_finish = (sent == fin_at);
      if (sent == stall_at && waited < stall_len) begin
        bus.s_valid = 1'b0;
        waited++;
      end else if (bus.s_ready) begin
        bus.s_valid = 1'b1;
        bus.s_data = pix;
        pix++;
        sent++;
      end else begin
        bus.s_valid = 1'b0;
      end
    end
    chk("feed_count", sent, n);
  endtask

  // map_finish sampled on the 3rd edge after entering WAIT
  task automatic fin3();
    @(negedge clk);
    bus.s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.map_finish = 1'b1;
    @(negedge clk);
    bus.map_finish = 1'b0;
  endtask

  task automatic order_chk(input string tag);
    bad = 0;
    for (int i = 0; i < flag_q.size(); i++)
      if (flag_q[i] !== 16'(base + i)) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    clk = 1'b0;
    nrst = 1'b0;
    checks = 0;
    errors = 0;
    n_start = 0;
    n_flag = 0;
    n_done = 0;
    pix = 16'h0100;
    last_val = '0;
    bus.cfg_valid = 1'b0;
    bus.cfg_num_ch = '0;
    bus.abort = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.map_finish = 1'b0;

    #2 nrst = 1'b1;
    #1;
    chk("rst_status", st(), 8'b1000_0000);
    chk("rst_new1", bus.map_new1, 0);
    chk("rst_ch", bus.ch_idx, 0);
    @(negedge clk);
    nrst = 1'b0;

    // two channels, continuous stream
    clr();
    base = pix;
    start_job(2);
    chk("t1_start_st", st(), 8'b0010_1000);
    feed(16, -1, 0, -1);
    chk("t1_ch0", bus.ch_idx, 0);
    chk("t1_ch0_gap", low_run, 0);
    fin3();
    feed(16, -1, 0, -1);
    chk("t1_ch1", bus.ch_idx, 1);
    fin3();
    repeat (3) @(negedge clk);
    chk("t1_starts", n_start, 2);
    chk("t1_flags", n_flag, 32);
    order_chk("t1_order");
    chk("t1_done", n_done, 1);
    chk("t1_end_st", st(), 8'b1000_0000);
    chk("t1_ch_hold", bus.ch_idx, 1);

    // zero-channel job
    clr();
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_num_ch = '0;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    chk("t2_done_st", st(), 8'b1000_0100);
    @(negedge clk);
    chk("t2_after_st", st(), 8'b1000_0000);
    chk("t2_starts", n_start, 0);

    // 5-cycle stall mid-channel
    clr();
    base = pix;
    start_job(1);
    feed(16, 8, 5, -1);
    chk("t3_low_run", low_run, 5);
    chk("t3_stable", unstable, 0);
    fin3();
    repeat (3) @(negedge clk);
    chk("t3_flags", n_flag, 16);
    order_chk("t3_order");
    chk("t3_done", n_done, 1);

    // map_finish never returns
    clr();
    start_job(1);
    feed(16, -1, 0, -1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("t4_pre_to", bus.err_timeout, 0);
    @(negedge clk);
    chk("t4_to_st", st(), 8'b0000_1110);
    @(negedge clk);
    chk("t4_idle_st", st(), 8'b1000_0010);

    // early map_finish during FEED
    clr();
    base = pix;
    start_job(1);
    chk("t5_err_clr", st(), 8'b0010_1000);
    feed(16, -1, 0, 4);
    chk("t5_early", bus.err_early, 1);
    fin3();
    repeat (3) @(negedge clk);
    chk("t5_flags", n_flag, 16);
    order_chk("t5_order");
    chk("t5_end_st", st(), 8'b1000_0001);

    // abort together with map_finish in WAIT
    clr();
    start_job(2);
    feed(16, -1, 0, -1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    @(negedge clk);
    bus.abort = 1'b1;
    bus.map_finish = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.map_finish = 1'b0;
    chk("t6_idle_st", st(), 8'b1000_0000);
    repeat (4) @(negedge clk);
    chk("t6_done", n_done, 0);
    chk("t6_starts", n_start, 1);
    chk("t6_ch", bus.ch_idx, 0);

    // reset in channel 1 FEED
    clr();
    start_job(2);
    feed(16, -1, 0, -1);
    fin3();
    feed(5, -1, 0, -1);
    chk("t7_pre_ch", bus.ch_idx, 1);
    chk("t7_pre_flag", bus.map_flag, 1);
    #2 nrst = 1'b1;
    #1;
    chk("t7_rst_st", st(), 8'b1000_0000);
    chk("t7_rst_new1", bus.map_new1, 0);
    chk("t7_rst_ch", bus.ch_idx, 0);
    bus.s_valid = 1'b0;
    n_done = 0;
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t7_no_done", n_done, 0);
    start_job(1);
    chk("t7_new_ch", bus.ch_idx, 0);
    feed(16, -1, 0, -1);
    fin3();
    repeat (3) @(negedge clk);
    chk("t7_new_done", n_done, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
